// File: rtl/fetch_npc_ctrl.sv
// Fetch-stage next-PC selection and F/D pipeline register, with the stall-held
// pending-redirect latch and the sticky out-of-range fetch flag.
module fetch_npc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic [31:0] npc,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic        fetch_err
);

  // Bounds widened to 33 bits so IM_BASE + 4*IM_WORDS cannot wrap.
  localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] fd_pc_q,    fd_pc_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic        fd_valid_q, fd_valid_d;
  logic        err_q,      err_d;
  logic        pend_v_q,   pend_v_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        in_range;

  always_comb begin
    in_range = (pc_f[1:0] == 2'b00) &&
               ({1'b0, pc_f} >= IM_LO) &&
               ({1'b0, pc_f} <  IM_HI);
  end

  // The PC register has no enable, so a stall is expressed by feeding pc_f back.
  always_comb begin
    npc = pc_f + 32'd4;
    if (rst)
      npc = RESET_PC;
    else if (stall)
      npc = pc_f;
    else if (br_valid)
      npc = br_target;
    else if (pend_v_q)
      npc = pend_tgt_q;
  end

  always_comb begin
    fd_pc_d    = fd_pc_q;
    fd_instr_d = fd_instr_q;
    fd_valid_d = fd_valid_q;
    err_d      = err_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;

    if (stall) begin
      if (br_valid) begin
        pend_v_d   = 1'b1;
        pend_tgt_d = br_target;
      end
    end else begin
      // Delay slot is never flushed: F always advances into D when not stalled.
      fd_pc_d = pc_f;
      if (in_range) begin
        fd_instr_d = instr_f;
        fd_valid_d = 1'b1;
      end else begin
        fd_instr_d = '0;
        fd_valid_d = 1'b0;
        err_d      = 1'b1;
      end
      if (br_valid || pend_v_q)
        pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fd_pc_q    <= RESET_PC;
      fd_instr_q <= '0;
      fd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      fd_pc_q    <= fd_pc_d;
      fd_instr_q <= fd_instr_d;
      fd_valid_q <= fd_valid_d;
      err_q      <= err_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_d      = fd_pc_q;
  assign instr_d   = fd_instr_q;
  assign valid_d   = fd_valid_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_npc_ctrl.sv
// Bench for fetch_npc_ctrl: directed vector table plus a randomized run
// against a small reference model, D-stage results checked via a queue.
module tb_fetch_npc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic [31:0] npc;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        fetch_err;

  fetch_npc_ctrl #(
    .RESET_PC(32'h0000_3000),
    .IM_BASE (32'h0000_3000),
    .IM_WORDS(4096)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_f     (pc_f),
    .instr_f  (instr_f),
    .stall    (stall),
    .br_valid (br_valid),
    .br_target(br_target),
    .npc      (npc),
    .pc_d     (pc_d),
    .instr_d  (instr_d),
    .valid_d  (valid_d),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] e_npc;
    logic [31:0] e_pcd;
    logic [31:0] e_ins;
    logic        e_vld;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] pcd;
    logic [31:0] ins;
    logic        vld;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic [31:0] p, input logic [31:0] en, input logic [31:0] epcd,
                     input logic [31:0] eins, input logic evld, input logic eerr);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.pc = p;
    v.e_npc = en; v.e_pcd = epcd; v.e_ins = eins; v.e_vld = evld; v.e_err = eerr;
    vecs.push_back(v);
  endtask

  // Drive one cycle, check npc mid-cycle, queue the expected D-stage state,
  // then compare it just after the edge.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic [31:0] p, input logic [31:0] en, input exp_t e);
    exp_t got;
    @(negedge clk);
    rst = r; stall = s; br_valid = b; br_target = t; pc_f = p;
    instr_f = 32'h1111_0000 + p;
    #1;
    check("npc", npc, en);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("pc_d",      pc_d,             got.pcd);
      check("instr_d",   instr_d,          got.ins);
      check("valid_d",   {31'd0, valid_d}, {31'd0, got.vld});
      check("fetch_err", {31'd0, fetch_err}, {31'd0, got.err});
    end
  endtask

  // Reference model state for the randomized section
  logic        m_pend_v;
  logic [31:0] m_pend_tgt;
  exp_t        m_d;
  logic [31:0] m_pc;

  initial begin
    exp_t e;
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    pc_f = 32'h3000; instr_f = '0;

    //   rst stall br  tgt         pc_f          npc           pc_d          instr_d        vld err
    add(1, 0, 0, 32'h0,    32'h3000,     32'h3000,     32'h3000,     32'h0,         0, 0);
    add(0, 0, 0, 32'h0,    32'h3000,     32'h3004,     32'h3000,     32'h1111_3000, 1, 0);
    add(0, 0, 0, 32'h0,    32'h3004,     32'h3008,     32'h3004,     32'h1111_3004, 1, 0);
    add(0, 0, 1, 32'h3100, 32'h3008,     32'h3100,     32'h3008,     32'h1111_3008, 1, 0);
    add(0, 0, 0, 32'h0,    32'h3100,     32'h3104,     32'h3100,     32'h1111_3100, 1, 0);
    add(0, 0, 0, 32'h0,    32'h3008,     32'h300C,     32'h3008,     32'h1111_3008, 1, 0);
    add(0, 1, 0, 32'h0,    32'h300C,     32'h300C,     32'h3008,     32'h1111_3008, 1, 0);
    add(0, 1, 0, 32'h0,    32'h300C,     32'h300C,     32'h3008,     32'h1111_3008, 1, 0);
    add(0, 1, 0, 32'h0,    32'h300C,     32'h300C,     32'h3008,     32'h1111_3008, 1, 0);
    add(0, 0, 0, 32'h0,    32'h300C,     32'h3010,     32'h300C,     32'h1111_300C, 1, 0);
    add(0, 1, 1, 32'h3200, 32'h3010,     32'h3010,     32'h300C,     32'h1111_300C, 1, 0);
    add(0, 1, 1, 32'h3300, 32'h3010,     32'h3010,     32'h300C,     32'h1111_300C, 1, 0);
    add(0, 0, 0, 32'h0,    32'h3010,     32'h3300,     32'h3010,     32'h1111_3010, 1, 0);
    add(0, 0, 0, 32'h0,    32'h3300,     32'h3304,     32'h3300,     32'h1111_3300, 1, 0);
    add(0, 1, 1, 32'h3400, 32'h3304,     32'h3304,     32'h3300,     32'h1111_3300, 1, 0);
    add(0, 0, 1, 32'h3500, 32'h3304,     32'h3500,     32'h3304,     32'h1111_3304, 1, 0);
    add(0, 0, 0, 32'h0,    32'h3500,     32'h3504,     32'h3500,     32'h1111_3500, 1, 0);
    add(0, 0, 0, 32'h0,    32'h2FFC,     32'h3000,     32'h2FFC,     32'h0,         0, 1);
    add(0, 0, 0, 32'h0,    32'h3002,     32'h3006,     32'h3002,     32'h0,         0, 1);
    add(0, 0, 0, 32'h0,    32'h7000,     32'h7004,     32'h7000,     32'h0,         0, 1);
    add(0, 0, 0, 32'h0,    32'h6FFC,     32'h7000,     32'h6FFC,     32'h1111_6FFC, 1, 1);
    add(0, 0, 0, 32'h0,    32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 32'h0,        0, 1);
    add(0, 1, 1, 32'h3600, 32'h3004,     32'h3004,     32'hFFFF_FFFC, 32'h0,        0, 1);
    add(1, 1, 0, 32'h0,    32'h3004,     32'h3000,     32'h3000,     32'h0,         0, 0);
    add(0, 0, 0, 32'h0,    32'h3000,     32'h3004,     32'h3000,     32'h1111_3000, 1, 0);
    add(0, 1, 0, 32'h0,    32'h7000,     32'h7000,     32'h3000,     32'h1111_3000, 1, 0);
    add(0, 0, 0, 32'h0,    32'h3004,     32'h3008,     32'h3004,     32'h1111_3004, 1, 0);
    add(1, 0, 1, 32'h3700, 32'h3008,     32'h3000,     32'h3000,     32'h0,         0, 0);
    add(0, 0, 0, 32'h0,    32'h3000,     32'h3004,     32'h3000,     32'h1111_3000, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      e.pcd = vecs[i].e_pcd; e.ins = vecs[i].e_ins;
      e.vld = vecs[i].e_vld; e.err = vecs[i].e_err;
      cycle(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].pc, vecs[i].e_npc, e);
    end

    // Reset held for two cycles: npc pinned, D stays a bubble.
    e = '{pcd: 32'h3000, ins: 32'h0, vld: 1'b0, err: 1'b0};
    cycle(1, 0, 0, 32'h0, 32'h3000, 32'h3000, e);
    cycle(1, 1, 1, 32'h3800, 32'h3000, 32'h3000, e);

    // Randomized closed loop: the bench acts as the PC register (pc_f <= npc).
    m_pend_v = 1'b0; m_pend_tgt = '0; m_d = e; m_pc = 32'h3000;
    for (int c = 0; c < 300; c++) begin
      logic        s, b, inr;
      logic [31:0] t, en;
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 4) == 0);
      t = 32'h3000 + (32'($urandom_range(0, 1023)) << 2);
      if (s)            en = m_pc;
      else if (b)       en = t;
      else if (m_pend_v) en = m_pend_tgt;
      else              en = m_pc + 32'd4;
      inr = (m_pc[1:0] == 2'b00) && (m_pc >= 32'h3000) && (m_pc < 32'h7000);
      if (s) begin
        if (b) begin m_pend_v = 1'b1; m_pend_tgt = t; end
      end else begin
        m_d.pcd = m_pc;
        m_d.ins = inr ? 32'h1111_0000 + m_pc : 32'h0;
        m_d.vld = inr;
        if (!inr) m_d.err = 1'b1;
        m_pend_v = 1'b0;
      end
      cycle(0, s, b, t, m_pc, en, m_d);
      m_pc = en;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_npc_ctrl.md
Name: fetch_npc_ctrl

Overview:
- Consumer end of the fetch-stage program counter. It takes the current fetch PC and the instruction memory word read at that address.
- It computes the next PC and returns it to the PC register.
- It owns the F/D pipeline register: stall hold, delay-slot redirect, a pending-redirect latch and an out-of-range fetch check.
- It sits between the PC register / instruction memory and the D stage of the 5-stage MIPS core.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; also the reset value of pc_d.
- IM_BASE, 32'h0000_3000, lowest valid instruction address.
- IM_WORDS, 4096, instruction memory depth in 32-bit words.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- pc_f, input, 32, current fetch PC from the PC register.
- instr_f, input, 32, instruction memory read data at pc_f (combinational).
- stall, input, 1, hazard unit freeze of F and D.
- br_valid, input, 1, one-cycle pulse from D: taken branch/jump/jr.
- br_target, input, 32, redirect target; valid when br_valid=1.
- npc, output, 32, next PC, registered by the PC register every cycle.
- pc_d, output, 32, D-stage PC.
- instr_d, output, 32, D-stage instruction.
- valid_d, output, 1, D-stage slot holds a real fetched instruction.
- fetch_err, output, 1, sticky flag: an out-of-range or misaligned pc_f was fetched.

Behaviour:
- Reset (rst=1 at an edge):
  - pc_d=RESET_PC, instr_d=0, valid_d=0, fetch_err=0.
  - Pending latch cleared: pend_v=0, pend_tgt=0.
  - While rst=1, npc=RESET_PC combinationally.
  - Reset overrides every other input in the same cycle.
- npc selection (combinational, priority high to low):
  1. rst: RESET_PC.
  2. stall=1: pc_f (PC holds, since the PC register has no enable).
  3. br_valid=1: br_target.
  4. pend_v=1: pend_tgt.
  5. Otherwise: pc_f+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Delay slot: no flush on redirect. The instruction already in F (the delay slot) advances into D normally in the redirect cycle.
- Pending-redirect latch:
  - br_valid=1 with stall=1 at an edge: pend_v<=1, pend_tgt<=br_target. A newer pulse overwrites an older pending target.
  - Cycle with stall=0 and (br_valid or pend_v): the redirect is consumed and pend_v<=0. A br_valid in that cycle takes priority over the pending target.
- F/D register (edge, rst=0):
  - stall=1: pc_d, instr_d, valid_d hold.
  - stall=0 and fetch in range: pc_d<=pc_f, instr_d<=instr_f, valid_d<=1.
  - stall=0 and fetch out of range: pc_d<=pc_f, instr_d<=0 (nop), valid_d<=0, fetch_err<=1.
- Range check:
  - In range means pc_f[1:0]==0 and IM_BASE <= pc_f < IM_BASE+4*IM_WORDS.
  - The comparison uses 33-bit arithmetic so the upper bound does not overflow.
- fetch_err is set only on a non-stalled out-of-range fetch. It stays set until rst.
- First cycle after reset:
  - D holds a bubble (valid_d=0). F presents RESET_PC, and npc=RESET_PC+4 when not stalled and no redirect is pending.
- Latency: instruction at pc_f appears on instr_d one cycle after a non-stalled edge. A redirect pulse appears on npc in the same cycle and on pc_f one cycle later.

Test Plan:
- Reset then free-run 4 cycles, IM returning 32'h1111_0000+pc → npc sequence 3004, 3008, 300C. instr_d lags pc_f by one cycle. valid_d=0 for the first cycle after reset, then 1.
- br_valid=1, br_target=32'h0000_3100 while pc_f=3008 → npc=3100. The delay slot at 3008 enters D with valid_d=1. Next cycle pc_f=3100.
- stall=1 for 3 cycles at pc_f=300C → npc=300C every cycle. pc_d, instr_d, valid_d unchanged. stall release → npc=3010.
- br_valid pulse (target 3200) during stall, then a second pulse (target 3300) still during stall, then stall=0 → pend_v set after the first pulse. On release npc=3300 for exactly one cycle, then pend_v=0.
- pc_f=32'h0000_2FFC, then 32'h0000_3002, then 32'h0000_7000 (IM_WORDS=4096), all unstalled → each gives instr_d=0 and valid_d=0. fetch_err=1 after the first and stays 1 until rst.
- pc_f=32'hFFFF_FFFC, no stall or redirect → npc=0. Assert rst mid-stall with pend_v=1 → next cycle pend_v=0, pc_d=3000, valid_d=0, fetch_err=0, npc=3000 while rst is high.
